// File: rtl/uart_rx_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl_pkg
// Shared definitions for the UART receive-side frame controller:
//   - rx_state_e   : frame FSM states
//   - PRESCALE_6/8 : supported oversampling ratios
//   - PAR_EVEN/ODD : parity-type encodings carried on PAR_TYP
//   - expected_parity() : parity bit a correct frame must carry
// ---------------------------------------------------------------------------
package uart_rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [4:0] PRESCALE_6 = 5'd6;
    localparam logic [4:0] PRESCALE_8 = 5'd8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Given the XOR of the data bits, return the parity bit the sender
    // should have transmitted for the selected parity type.
    function automatic logic expected_parity(input logic even_par, input logic par_typ);
        logic p;
        p = even_par;
        unique case (par_typ)
            PAR_EVEN: p = even_par;
            PAR_ODD:  p = ~even_par;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// ---------------------------------------------------------------------------
// edge_bit_counter
// Oversample (edge) counter and bit counter for one UART frame.
//   clk       in  : RX oversampling clock
//   rst       in  : asynchronous active-low reset
//   enable    in  : counters run while high, are held at zero while low
//   Prescale  in  : oversampling ratio for the current frame
//   edge_cnt  out : oversample index within the current bit, 0..Prescale-1
//   bit_cnt   out : number of completed bits since the frame started
//   bit_done  out : high during the last oversample of a bit (the eval point)
// ---------------------------------------------------------------------------
module edge_bit_counter #(
    parameter int BIT_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [4:0]           Prescale,
    output logic [2:0]           edge_cnt,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 bit_done
);

    logic [2:0]           edge_q, edge_d;
    logic [BIT_CNT_W-1:0] bit_q,  bit_d;

    assign bit_done = enable && ({2'b00, edge_q} == (Prescale - 5'd1));
    assign edge_cnt = edge_q;
    assign bit_cnt  = bit_q;

    // Edge counter wraps at Prescale-1 and bumps the bit counter on wrap.
    // Holding both at zero while disabled means every frame starts clean.
    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (!enable) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (bit_done) begin
            edge_d = '0;
            bit_d  = bit_q + 1'b1;
        end else begin
            edge_d = edge_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Receive-side UART frame controller: start detection, bit timing for the
// external majority sampler, LSB-first deserialisation, optional parity
// check and stop check. All outputs are registered.
//   clk          in  : RX oversampling clock
//   rst          in  : asynchronous active-low reset
//   RX_IN        in  : synchronised serial line, idle high
//   Prescale     in  : oversampling ratio (6 or 8), latched per frame
//   PAR_EN       in  : frame carries a parity bit, latched per frame
//   PAR_TYP      in  : 0 even / 1 odd parity, latched per frame
//   sampled_bit  in  : majority-voted bit from data_sampling
//   data_samp_en out : enable to data_sampling (high outside IDLE)
//   edge_cnt     out : oversample index within the current bit
//   P_DATA       out : last accepted byte
//   data_valid   out : one-cycle pulse when P_DATA is updated
//   par_err      out : one-cycle pulse on parity mismatch
//   stp_err      out : one-cycle pulse on bad stop bit
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [4:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  data_samp_en,
    output logic [2:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    // Enough range for start + data + parity + stop without wrapping.
    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 4);

    rx_state_e             state_q,    state_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [DATA_WIDTH-1:0] pdata_q,    pdata_d;
    logic                  valid_q,    valid_d;
    logic                  par_err_q,  par_err_d;
    logic                  stp_err_q,  stp_err_d;
    logic                  samp_en_q,  samp_en_d;
    logic                  bad_q,      bad_d;
    logic [4:0]            prescale_q, prescale_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_typ_q,  par_typ_d;

    logic                  cnt_en;
    logic                  bit_done;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    assign cnt_en = (state_q != IDLE);

    edge_bit_counter #(
        .BIT_CNT_W (BIT_CNT_W)
    ) u_edge_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .enable   (cnt_en),
        .Prescale (prescale_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done)
    );

    assign data_samp_en = samp_en_q;
    assign P_DATA       = pdata_q;
    assign data_valid   = valid_q;
    assign par_err      = par_err_q;
    assign stp_err      = stp_err_q;

    // Frame FSM. Everything of interest happens at bit_done, the last
    // oversample of a bit, where sampled_bit has settled. The bit counter
    // reads 1 during the first data bit, so the last data bit is the one
    // where it equals DATA_WIDTH.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        pdata_d    = pdata_q;
        bad_d      = bad_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        valid_d    = 1'b0;
        par_err_d  = 1'b0;
        stp_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d    = START;
                    bad_d      = 1'b0;
                    // Unsupported ratios fall back to 8 so the 3-bit edge
                    // counter can never run past its range.
                    prescale_d = (Prescale == PRESCALE_6) ? PRESCALE_6 : PRESCALE_8;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt == BIT_CNT_W'(DATA_WIDTH)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    if (sampled_bit != expected_parity(^shift_q, par_typ_q)) begin
                        bad_d     = 1'b1;
                        par_err_d = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!sampled_bit) begin
                        stp_err_d = 1'b1;
                    end else if (!bad_q) begin
                        pdata_d = shift_q;
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        samp_en_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            pdata_q    <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            samp_en_q  <= 1'b0;
            bad_q      <= 1'b0;
            prescale_q <= PRESCALE_8;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            pdata_q    <= pdata_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
            samp_en_q  <= samp_en_d;
            bad_q      <= bad_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
// Self-checking bench for uart_rx_frame_ctrl. Each frame is turned into a
// per-cycle expectation table from the frame timing rules (eval of bit n at
// k+(n+1)*Prescale, outcome at the stop eval), and a negedge monitor
// compares every output against that table on every cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

    localparam int N = 16384;

    logic       clk;
    logic       rst;
    logic       RX_IN;
    logic [4:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       data_samp_en;
    logic [2:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int vectorCount = 0;
    int missCount   = 0;
    int cyc         = 0;

    bit       expValid [N];
    bit       expPar   [N];
    bit       expStp   [N];
    bit       expEn    [N];
    bit [2:0] expEdge  [N];
    bit [7:0] expLoad  [N];
    bit [7:0] expPData = 8'h00;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .sampled_bit  (sampled_bit),
        .data_samp_en (data_samp_en),
        .edge_cnt     (edge_cnt),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err)
    );

    // Free-running clock; cyc equals the number of rising edges so far.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Every cycle, away from the active edge, compare all outputs with the
    // expectation table entry for the edge that just happened.
    always @(negedge clk) begin
        if (cyc < N) begin
            if (expValid[cyc]) expPData = expLoad[cyc];
            checkOutput("data_valid",   {31'd0, data_valid},   {31'd0, expValid[cyc]});
            checkOutput("par_err",      {31'd0, par_err},      {31'd0, expPar[cyc]});
            checkOutput("stp_err",      {31'd0, stp_err},      {31'd0, expStp[cyc]});
            checkOutput("data_samp_en", {31'd0, data_samp_en}, {31'd0, expEn[cyc]});
            checkOutput("edge_cnt",     {29'd0, edge_cnt},     {29'd0, expEdge[cyc]});
            checkOutput("P_DATA",       {24'd0, P_DATA},       {24'd0, expPData});
        end else begin
            $display("[TB] FAIL cycle_budget: got %0d cycles, limit %0d", cyc, N);
            $fatal(1, "[TB] cycle budget exhausted");
        end
    end

    // Record the expected activity for a frame whose start bit is seen at
    // edge k and whose last evaluated bit lands at edge k+nbits*p.
    task automatic modelFrame(input int k, input int p, input int nbits, input bit parEn,
                              input bit parOk, input bit stopOk, input bit [7:0] data);
        int endCyc;
        endCyc = k + nbits * p;
        for (int c = k; c < endCyc && c < N; c++) begin
            expEn[c]   = 1'b1;
            expEdge[c] = 3'((c - k) % p);
        end
        if (endCyc < N) begin
            if (parEn && !parOk) expPar[k + 10 * p] = 1'b1;
            if (!stopOk) begin
                expStp[endCyc] = 1'b1;
            end else if (!parEn || parOk) begin
                expValid[endCyc] = 1'b1;
                expLoad[endCyc]  = data;
            end
        end
    endtask

    task automatic clearFrom(input int c0);
        for (int c = c0; c < N; c++) begin
            expValid[c] = 1'b0;
            expPar[c]   = 1'b0;
            expStp[c]   = 1'b0;
            expEn[c]    = 1'b0;
            expEdge[c]  = 3'd0;
        end
    endtask

    task automatic applyIdle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            RX_IN       = 1'b1;
            sampled_bit = 1'($urandom);
            Prescale    = 5'($urandom);
        end
    endtask

    // Send one frame. sampled_bit carries the intended bit only in the last
    // cycle of each bit (the eval point) and is random otherwise; RX_IN and
    // the configuration inputs are scrambled once the frame is under way.
    // abortAt >= 0 pulls reset that many cycles after the start edge.
    task automatic applyStimulus(input int p, input bit parEn, input bit parTyp, input bit [7:0] data,
                                 input bit parOk, input bit stopOk, input int abortAt);
        bit bits [0:10];
        bit goodPar;
        int nbits;
        int k;
        goodPar = 1'(($countones(data) % 2) == 1) ^ parTyp;
        nbits   = parEn ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i + 1] = data[i];
        if (parEn) bits[9] = parOk ? goodPar : ~goodPar;
        bits[nbits - 1] = stopOk;

        @(posedge clk); #2;
        k           = cyc + 1;
        RX_IN       = 1'b0;
        Prescale    = 5'(p);
        PAR_EN      = parEn;
        PAR_TYP     = parTyp;
        sampled_bit = 1'($urandom);
        modelFrame(k, p, nbits, parEn, parOk, stopOk, data);

        for (int j = 0; j < nbits * p; j++) begin
            @(posedge clk); #2;
            if (j == abortAt) begin
                rst = 1'b0;
                #1;
                checkOutput("rst_data_valid",   {31'd0, data_valid},   32'd0);
                checkOutput("rst_par_err",      {31'd0, par_err},      32'd0);
                checkOutput("rst_stp_err",      {31'd0, stp_err},      32'd0);
                checkOutput("rst_data_samp_en", {31'd0, data_samp_en}, 32'd0);
                checkOutput("rst_edge_cnt",     {29'd0, edge_cnt},     32'd0);
                checkOutput("rst_P_DATA",       {24'd0, P_DATA},       32'd0);
                clearFrom(cyc);
                expPData = 8'h00;
                RX_IN    = 1'b1;
                repeat (3) @(posedge clk);
                #2;
                rst = 1'b1;
                return;
            end
            RX_IN       = 1'($urandom);
            Prescale    = 5'($urandom);
            PAR_EN      = 1'($urandom);
            PAR_TYP     = 1'($urandom);
            sampled_bit = ((j % p) == p - 1) ? bits[j / p] : 1'($urandom);
        end
    endtask

    // Start bit that collapses: RX_IN low for two cycles, and the sampler
    // reports 1 at the start-bit eval, so the frame is abandoned silently.
    task automatic applyGlitch(input int p);
        int k;
        @(posedge clk); #2;
        k           = cyc + 1;
        RX_IN       = 1'b0;
        Prescale    = 5'(p);
        sampled_bit = 1'($urandom);
        for (int c = k; c < k + p; c++) begin
            expEn[c]   = 1'b1;
            expEdge[c] = 3'((c - k) % p);
        end
        for (int j = 0; j < p; j++) begin
            @(posedge clk); #2;
            RX_IN       = (j >= 1);
            sampled_bit = (j == p - 1) ? 1'b1 : 1'($urandom);
        end
    endtask

    initial begin
        rst         = 1'b0;
        RX_IN       = 1'b1;
        Prescale    = 5'd8;
        PAR_EN      = 1'b0;
        PAR_TYP     = 1'b0;
        sampled_bit = 1'b1;
        #1;
        checkOutput("reset_P_DATA",       {24'd0, P_DATA},       32'd0);
        checkOutput("reset_data_valid",   {31'd0, data_valid},   32'd0);
        checkOutput("reset_data_samp_en", {31'd0, data_samp_en}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        applyIdle(3);

        $display("[TB] directed frames");
        applyStimulus(8, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, -1);
        applyIdle(4);
        applyStimulus(8, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1, -1);
        applyIdle(4);
        applyStimulus(6, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, -1);
        applyIdle(4);
        applyGlitch(8);
        applyIdle(4);
        applyStimulus(8, 1'b0, 1'b0, 8'h12, 1'b1, 1'b1, -1);
        applyStimulus(8, 1'b0, 1'b0, 8'h34, 1'b1, 1'b1, -1);
        applyIdle(4);
        applyStimulus(8, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 40);
        applyIdle(2);
        applyStimulus(8, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, -1);
        applyIdle(4);

        $display("[TB] random frames");
        for (int f = 0; f < 40; f++) begin
            int  p;
            int  gap;
            bit  pe, pt, po, so;
            p   = ($urandom_range(0, 1) == 1) ? 8 : 6;
            pe  = 1'($urandom);
            pt  = 1'($urandom);
            po  = ($urandom_range(0, 3) != 0);
            so  = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) applyGlitch(p);
            else applyStimulus(p, pe, pt, 8'($urandom), po, so, -1);
            applyIdle(gap);
        end
        applyIdle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
